// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared state, PC-select and cause encodings for the exception path
package mips_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FLUSH    = 3'd1,
        ST_REDIRECT = 3'd2,
        ST_HANDLER  = 3'd3,
        ST_RETURN   = 3'd4,
        ST_HALT     = 3'd5
    } exc_state_e;

    localparam logic [1:0] PCSEL_NORMAL  = 2'd0;
    localparam logic [1:0] PCSEL_HANDLER = 2'd1;
    localparam logic [1:0] PCSEL_RETURN  = 2'd2;

    localparam logic [2:0] CAUSE_NONE   = 3'd0;
    localparam logic [2:0] CAUSE_OPCODE = 3'd1;
    localparam logic [2:0] CAUSE_FUNC   = 3'd2;
    localparam logic [2:0] CAUSE_REG    = 3'd3;
    localparam logic [2:0] CAUSE_OVF    = 3'd4;

endpackage

// File: rtl/exception_controller.sv
// rtl/exception_controller.sv - sequences flush, handler redirect, return and double-fault halt
module exception_controller
    import mips_pkg::*;
#(
    parameter int                    PC_WIDTH      = 6,
    parameter int                    CAUSE_WIDTH   = 3,
    parameter logic [PC_WIDTH-1:0]   HANDLER_ADDR  = 6'd60,
    parameter int                    FLUSH_CYCLES  = 3,
    parameter int                    RETURN_OFFSET = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CAUSE_WIDTH-1:0] ExceptionCause,
    input  logic [PC_WIDTH-1:0]    ExceptionPC,
    input  logic                   Eret,
    output logic                   ExcClear,
    output logic                   PCWriteEn,
    output logic [1:0]             PCSel,
    output logic [PC_WIDTH-1:0]    PCTarget,
    output logic                   FlushIFID,
    output logic                   FlushIDEX,
    output logic                   FlushEXMEM,
    output logic [PC_WIDTH-1:0]    EPC,
    output logic [CAUSE_WIDTH-1:0] CauseReg,
    output logic                   InHandler,
    output logic                   Halted,
    output logic [7:0]             ExcCount
);

    exc_state_e             state_q, state_d;
    logic [3:0]             flush_cnt_q, flush_cnt_d;
    logic [PC_WIDTH-1:0]    epc_q, epc_d;
    logic [CAUSE_WIDTH-1:0] cause_q, cause_d;
    logic [7:0]             exc_count_q, exc_count_d;
    logic                   pending;

    assign pending = (ExceptionCause != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
            epc_q       <= '0;
            cause_q     <= '0;
            exc_count_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            epc_q       <= epc_d;
            cause_q     <= cause_d;
            exc_count_q <= exc_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        epc_d       = epc_q;
        cause_d     = cause_q;
        exc_count_d = exc_count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pending) begin
                    epc_d       = ExceptionPC;
                    cause_d     = ExceptionCause;
                    exc_count_d = (exc_count_q == 8'hFF) ? exc_count_q : exc_count_q + 8'd1;
                    flush_cnt_d = 4'(FLUSH_CYCLES - 1);
                    state_d     = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == 4'd0) state_d = ST_REDIRECT;
                else                     flush_cnt_d = flush_cnt_q - 4'd1;
            end
            ST_REDIRECT: state_d = ST_HANDLER;
            // A fault inside the handler wins over a same-cycle Eret.
            ST_HANDLER: begin
                if (pending)   state_d = ST_HALT;
                else if (Eret) state_d = ST_RETURN;
            end
            ST_RETURN: state_d = ST_IDLE;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ExcClear   = 1'b0;
        PCWriteEn  = 1'b1;
        PCSel      = PCSEL_NORMAL;
        PCTarget   = '0;
        FlushIFID  = 1'b0;
        FlushIDEX  = 1'b0;
        FlushEXMEM = 1'b0;
        InHandler  = 1'b0;
        Halted     = 1'b0;
        unique case (state_q)
            ST_IDLE: ;
            ST_FLUSH: begin
                PCWriteEn  = 1'b0;
                FlushIFID  = 1'b1;
                FlushIDEX  = 1'b1;
                FlushEXMEM = 1'b1;
            end
            ST_REDIRECT: begin
                PCSel     = PCSEL_HANDLER;
                PCTarget  = HANDLER_ADDR;
                ExcClear  = 1'b1;
                FlushIFID = 1'b1;
            end
            ST_HANDLER: InHandler = 1'b1;
            ST_RETURN: begin
                PCSel     = PCSEL_RETURN;
                PCTarget  = epc_q + PC_WIDTH'(RETURN_OFFSET);
                FlushIFID = 1'b1;
            end
            ST_HALT: begin
                Halted     = 1'b1;
                PCWriteEn  = 1'b0;
                FlushIFID  = 1'b1;
                FlushIDEX  = 1'b1;
                FlushEXMEM = 1'b1;
            end
            default: ;
        endcase
    end

    assign EPC      = epc_q;
    assign CauseReg = cause_q;
    assign ExcCount = exc_count_q;

endmodule

// File: tb/tb_exception_controller.sv
// tb/tb_exception_controller.sv - directed stimulus with a behavioural model checked every cycle
module tb_exception_controller;

    localparam int FLUSH_N = 3;
    localparam int HANDLER = 60;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] ExceptionCause;
    logic [5:0] ExceptionPC;
    logic       Eret;
    logic       ExcClear, PCWriteEn, FlushIFID, FlushIDEX, FlushEXMEM, InHandler, Halted;
    logic [1:0] PCSel;
    logic [5:0] PCTarget, EPC;
    logic [2:0] CauseReg;
    logic [7:0] ExcCount;

    int n_checks = 0;
    int n_fail   = 0;

    exception_controller dut (
        .clk(clk), .rst(rst),
        .ExceptionCause(ExceptionCause), .ExceptionPC(ExceptionPC), .Eret(Eret),
        .ExcClear(ExcClear), .PCWriteEn(PCWriteEn), .PCSel(PCSel), .PCTarget(PCTarget),
        .FlushIFID(FlushIFID), .FlushIDEX(FlushIDEX), .FlushEXMEM(FlushEXMEM),
        .EPC(EPC), .CauseReg(CauseReg), .InHandler(InHandler), .Halted(Halted),
        .ExcCount(ExcCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what phase of exception handling the core is in, and for how many more flush cycles.
    string m_phase;
    int    m_flush_left;
    int    m_epc, m_cause, m_count;
    bit    m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = "idle"; m_epc = 0; m_cause = 0; m_count = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_phase == "idle") begin
                if (ExceptionCause != 0) begin
                    m_epc = ExceptionPC; m_cause = ExceptionCause;
                    m_count = (m_count >= 255) ? 255 : m_count + 1;
                    m_flush_left = FLUSH_N;
                    m_phase = "flush";
                end
            end else if (m_phase == "flush") begin
                m_flush_left--;
                if (m_flush_left == 0) m_phase = "redirect";
            end else if (m_phase == "redirect") m_phase = "handler";
            else if (m_phase == "handler") begin
                if (ExceptionCause != 0) m_phase = "halt";
                else if (Eret)           m_phase = "return";
            end else if (m_phase == "return") m_phase = "idle";
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            int flush_all, pcsel, target;
            flush_all = (m_phase == "flush" || m_phase == "halt");
            pcsel  = (m_phase == "redirect") ? 1 : (m_phase == "return") ? 2 : 0;
            target = (m_phase == "redirect") ? HANDLER : (m_phase == "return") ? (m_epc + 1) % 64 : 0;
            check("PCWriteEn",  PCWriteEn,  !flush_all);
            check("FlushIFID",  FlushIFID,  flush_all || pcsel != 0);
            check("FlushIDEX",  FlushIDEX,  flush_all);
            check("FlushEXMEM", FlushEXMEM, flush_all);
            check("ExcClear",   ExcClear,   m_phase == "redirect");
            check("PCSel",      PCSel,      pcsel);
            check("PCTarget",   PCTarget,   target);
            check("InHandler",  InHandler,  m_phase == "handler");
            check("Halted",     Halted,     m_phase == "halt");
            check("EPC",        EPC,        m_epc);
            check("CauseReg",   CauseReg,   m_cause);
            check("ExcCount",   ExcCount,   m_count);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Take an exception, run through the handler and return; expected return target is literal.
    task automatic exc_round(input int pc, input int cause, input int ret_target);
        ExceptionPC = 6'(pc); ExceptionCause = 3'(cause);
        step(1 + FLUSH_N);
        ExceptionCause = 3'd0;
        step(1);
        Eret = 1'b1;
        step(1);
        Eret = 1'b0;
        check("ret_target", PCTarget, ret_target);
        step(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ExceptionCause = 3'd0; ExceptionPC = 6'd0; Eret = 1'b0;
        step(2);
        rst = 1'b0;
        check("rst_PCWriteEn", PCWriteEn, 1);
        check("rst_PCSel", PCSel, 0);
        check("rst_ExcCount", ExcCount, 0);
        check("rst_Halted", Halted, 0);

        // Overflow exception at PC 12
        ExceptionCause = 3'd4; ExceptionPC = 6'd12;
        step(1);
        check("flush1_IDEX", FlushIDEX, 1);
        check("flush1_PCWriteEn", PCWriteEn, 0);
        step(2);
        check("flush3_EXMEM", FlushEXMEM, 1);
        step(1);
        check("redir_PCSel", PCSel, 1);
        check("redir_PCTarget", PCTarget, 60);
        check("redir_ExcClear", ExcClear, 1);
        check("redir_EPC", EPC, 12);
        check("redir_Cause", CauseReg, 4);
        check("redir_Count", ExcCount, 1);
        ExceptionCause = 3'd0;
        step(1);
        check("handler_In", InHandler, 1);
        Eret = 1'b1;
        step(1);
        Eret = 1'b0;
        check("ret_PCSel", PCSel, 2);
        check("ret_PCTarget", PCTarget, 13);
        check("ret_FlushIFID", FlushIFID, 1);
        step(1);
        check("idle_InHandler", InHandler, 0);
        check("idle_PCSel", PCSel, 0);

        // EPC wrap
        exc_round(63, 3, 0);
        check("wrap_Count", ExcCount, 2);

        // Eret in idle ignored
        Eret = 1'b1; step(2); Eret = 1'b0;
        check("idle_eret_PCSel", PCSel, 0);

        // Double fault with simultaneous Eret
        ExceptionCause = 3'd2; ExceptionPC = 6'd20;
        step(1 + FLUSH_N);
        ExceptionCause = 3'd0;
        step(1);
        ExceptionCause = 3'd1; Eret = 1'b1;
        step(1);
        Eret = 1'b0;
        check("halt_Halted", Halted, 1);
        check("halt_PCWriteEn", PCWriteEn, 0);
        check("halt_EPC", EPC, 20);
        check("halt_Cause", CauseReg, 2);
        step(6);
        check("halt_held", Halted, 1);
        check("halt_flush_held", FlushEXMEM, 1);
        rst = 1'b1; ExceptionCause = 3'd0;
        step(1);
        rst = 1'b0;
        check("recover_Halted", Halted, 0);
        check("recover_EPC", EPC, 0);
        check("recover_PCWriteEn", PCWriteEn, 1);

        // Saturation
        for (int i = 0; i < 256; i++) exc_round(i % 64, 1 + (i % 4), (i + 1) % 64);
        check("sat_Count", ExcCount, 255);
        exc_round(5, 4, 6);
        check("sat_Count_hold", ExcCount, 255);

        // Reset during the second flush cycle
        ExceptionCause = 3'd3; ExceptionPC = 6'd9;
        step(2);
        rst = 1'b1; ExceptionCause = 3'd0;
        step(1);
        rst = 1'b0;
        check("midrst_Count", ExcCount, 0);
        check("midrst_EPC", EPC, 0);
        check("midrst_FlushIDEX", FlushIDEX, 0);
        check("midrst_PCWriteEn", PCWriteEn, 1);
        step(2);
        check("midrst_stay_idle", PCWriteEn, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exception_controller.md
Name: exception_controller

Overview:
- Sequencer that acts on the pipeline exception detector's latched cause/PC.
- On a detected exception it:
  - freezes the PC and flushes the pipeline registers;
  - saves EPC and Cause;
  - redirects fetch to the handler vector and clears the detector;
  - tracks handler execution;
  - on Eret, returns fetch to EPC+RETURN_OFFSET.
- An exception raised inside the handler is a double fault and halts the core.
- Sits between the exception detector, the PC-select mux and the IF/ID, ID/EX, EX/MEM flush inputs.

Parameters:
- PC_WIDTH, 6, width of PC, EPC and targets.
- CAUSE_WIDTH, 3, width of cause code (0 = none; 1 opcode, 2 function, 3 register, 4 overflow).
- HANDLER_ADDR, 6'd60, handler vector.
- FLUSH_CYCLES, 3, cycles spent in FLUSH (1..15).
- RETURN_OFFSET, 1, added to EPC on return (word-addressed PC; skips the faulting instruction).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ExceptionCause  in  CAUSE_WIDTH  latched cause from detector; nonzero = pending.
- ExceptionPC  in  PC_WIDTH  PC of faulting instruction.
- Eret  in  1  return-from-exception decoded in ID.
- ExcClear  out  1  one-cycle synchronous clear to the detector's cause/PC registers.
- PCWriteEn  out  1  PC update enable.
- PCSel  out  2  0 = normal, 1 = handler, 2 = return.
- PCTarget  out  PC_WIDTH  target used when PCSel != 0.
- FlushIFID, FlushIDEX, FlushEXMEM  out  1 each  pipeline-register flushes.
- EPC  out  PC_WIDTH  saved exception PC.
- CauseReg  out  CAUSE_WIDTH  saved cause.
- InHandler  out  1  high while in HANDLER.
- Halted  out  1  double-fault halt.
- ExcCount  out  8  saturating count of accepted exceptions.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high; sampled only on the rising edge of clk.
- Reset (also mid-operation, any state): next cycle the state is IDLE and every output is 0 except PCWriteEn = 1 (EPC, CauseReg, ExcCount cleared; PCSel = 0, PCTarget = 0).
- States: IDLE, FLUSH, REDIRECT, HANDLER, RETURN, HALT. All outputs are Moore, decoded from registered state.
- IDLE:
  - PCWriteEn = 1; flushes = 0; PCSel = 0.
  - If ExceptionCause != 0 at an edge: EPC <= ExceptionPC; CauseReg <= ExceptionCause; ExcCount += 1, saturating at 255; load flush counter; go to FLUSH.
  - Eret in IDLE is ignored.
- FLUSH:
  - Lasts exactly FLUSH_CYCLES cycles.
  - PCWriteEn = 0; all three flushes = 1.
  - ExceptionCause is ignored.
  - Then go to REDIRECT.
- REDIRECT:
  - Lasts 1 cycle.
  - PCWriteEn = 1; PCSel = 1; PCTarget = HANDLER_ADDR; ExcClear = 1; FlushIFID = 1.
  - Then go to HANDLER.
  - The detector reads 0 from the first HANDLER cycle.
- HANDLER:
  - InHandler = 1; PCWriteEn = 1; PCSel = 0.
  - ExceptionCause != 0 → HALT. This takes priority over a simultaneous Eret.
  - Otherwise Eret = 1 → RETURN.
- RETURN:
  - Lasts 1 cycle.
  - PCSel = 2; PCTarget = (EPC + RETURN_OFFSET) mod 2^PC_WIDTH (wraps); FlushIFID = 1; PCWriteEn = 1.
  - Then go to IDLE.
  - An exception pending in this cycle is taken from IDLE on the next edge.
- HALT:
  - Halted = 1; PCWriteEn = 0; all flushes = 1; ExcClear = 0.
  - EPC and CauseReg keep the first fault.
  - Left only by rst.
- Latency:
  - Cause visible → first flush cycle: 1 edge.
  - Cause visible → PC = handler: FLUSH_CYCLES + 2 edges.
  - Eret → PC = return target: 2 edges.
- The detector must implement a synchronous clear on ExcClear (companion change to the detector).

Decomposition:
- Shared package (mips_pkg) holds:
  - state encoding localparams;
  - PCSel codes (PCSEL_NORMAL = 0, PCSEL_HANDLER = 1, PCSEL_RETURN = 2);
  - cause codes (CAUSE_NONE = 0, CAUSE_OPCODE = 1, CAUSE_FUNC = 2, CAUSE_REG = 3, CAUSE_OVF = 4).
- No sub-module. The flush counter and saturating ExcCount are small enough to stay inline.

Test Plan:
1. Reset then idle: rst = 1 for 2 cycles → PCWriteEn = 1, PCSel = 0, all flushes 0, ExcCount = 0, Halted = 0.
2. Overflow exception: ExceptionCause = 4, ExceptionPC = 6'd12 → next 3 cycles flushes = 1, PCWriteEn = 0; then one cycle PCSel = 1, PCTarget = 60, ExcClear = 1; EPC = 12, CauseReg = 4, ExcCount = 1.
3. Return: in HANDLER pulse Eret → next cycle PCSel = 2, PCTarget = 13, FlushIFID = 1; following cycle state is IDLE and InHandler = 0.
4. EPC wrap: ExceptionPC = 6'd63, then Eret → PCTarget = 0.
5. Double fault: in HANDLER assert Eret and ExceptionCause = 1 on the same cycle → Halted = 1, PCWriteEn = 0, flushes = 1 held indefinitely; EPC and CauseReg unchanged; rst recovers to IDLE.
6. Saturation and mid-operation reset:
   - 256 exception/Eret rounds → ExcCount holds at 255.
   - rst asserted during the second FLUSH cycle → next cycle IDLE, all outputs at reset values.
